// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, state encoding and lane offset helper for the score path
package nn_pkg;

  localparam int NUM_PE = 10;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic {COLLECT, FULL} state_t;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/relu_quant.sv
// rtl/relu_quant.sv - arithmetic shift, ReLU and saturation of one accumulator to a lane score
module relu_quant #(
  parameter int ACC_W  = 16,
  parameter int DATA_W = 8,
  parameter int SHIFT  = 4
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] q
);

  logic signed [ACC_W-1:0] shifted;

  // Floor rounding comes for free from the arithmetic shift on a signed operand.
  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted[ACC_W-1]) begin
      q = '0;
    end else if (|shifted[ACC_W-2:DATA_W]) begin
      q = '1;
    end else begin
      q = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/score_collector.sv
// rtl/score_collector.sv - collects per-lane accumulator results into the packed score vector
module score_collector #(
  parameter int NUM_PE = nn_pkg::NUM_PE,
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int ACC_W  = nn_pkg::ACC_W,
  parameter int SHIFT  = 4,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ACC_W-1:0]         psum,
  input  logic                     psum_valid,
  input  logic                     psum_last,
  output logic                     psum_ready,
  output logic [NUM_PE*DATA_W-1:0] vec_out,
  output logic                     vec_valid,
  input  logic                     vec_ready,
  output logic                     frame_err
);
  import nn_pkg::*;

  state_t                  state_q;
  state_t                  state_d;
  logic [IDX_W-1:0]        count_q;
  logic [NUM_PE*DATA_W-1:0] vec_q;
  logic                    err_q;
  logic [DATA_W-1:0]       lane_score;
  logic                    accept;
  logic                    last_lane;
  logic                    close;
  logic                    handshake;

  relu_quant #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_quant (
    .acc (psum),
    .q   (lane_score)
  );

  // Ready drops combinationally with reset so nothing is taken while it is held.
  assign psum_ready = (state_q == COLLECT) && !reset;
  assign vec_valid  = (state_q == FULL);
  assign vec_out    = vec_q;
  assign frame_err  = err_q;

  always_comb begin
    state_d   = state_q;
    accept    = psum_valid && psum_ready;
    last_lane = (count_q == IDX_W'(NUM_PE - 1));
    close     = accept && (psum_last || last_lane);
    handshake = (state_q == FULL) && vec_ready;
    case (state_q)
      COLLECT: if (close) state_d = FULL;
      FULL:    if (vec_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      count_q <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        for (int k = 0; k < NUM_PE; k++) begin
          if (count_q == IDX_W'(k)) begin
            vec_q[lane_lo(k, DATA_W) +: DATA_W] <= lane_score;
          end
        end
        count_q <= close ? '0 : count_q + IDX_W'(1);
      end
      // A clean frame has psum_last exactly on the final lane; any other closing is a framing error.
      if (close) begin
        err_q <= psum_last ^ last_lane;
      end
      if (handshake) begin
        vec_q <= '0;
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_collector.sv
// tb/tb_score_collector.sv - directed self-checking bench for score_collector
`timescale 1ns/1ps
module tb_score_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] psum;
  logic        psum_valid;
  logic        psum_last;
  logic        psum_ready;
  logic [79:0] vec_out;
  logic        vec_valid;
  logic        vec_ready;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  logic [79:0] held;

  score_collector dut (
    .clk        (clk),
    .reset      (reset),
    .psum       (psum),
    .psum_valid (psum_valid),
    .psum_last  (psum_last),
    .psum_ready (psum_ready),
    .vec_out    (vec_out),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int argmax(input logic [79:0] v);
    int best = 0;
    for (int k = 1; k < 10; k++) begin
      if (v[8*k +: 8] > v[8*best +: 8]) best = k;
    end
    return best;
  endfunction

  task automatic beat(input logic [15:0] v, input logic l);
    int n = 0;
    @(negedge clk);
    psum = v; psum_valid = 1'b1; psum_last = l;
    while (!psum_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept_wait", psum_ready, 1);
    @(posedge clk); #1;
    psum_valid = 1'b0; psum_last = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    vec_ready = 1'b1;
    @(posedge clk); #1;
    vec_ready = 1'b0;
    chk("hs_valid_low", vec_valid, 0);
    chk("hs_vec_cleared", vec_out, 0);
  endtask

  initial begin
    reset = 1'b1; psum = '0; psum_valid = 1'b0; psum_last = 1'b0; vec_ready = 1'b0;
    #12;
    chk("rst_psum_ready", psum_ready, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec_out", vec_out, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk); reset = 1'b0;

    // Full frame, no stalls, consumer always ready
    vec_ready = 1'b1;
    for (int k = 0; k < 9; k++) beat(16'(16 * k), 1'b0);
    chk("f1_not_valid_before_last", vec_valid, 0);
    beat(16'h0090, 1'b1);
    chk("f1_valid", vec_valid, 1);
    chk("f1_vec", vec_out, 80'h09080706050403020100);
    chk("f1_err", frame_err, 0);
    chk("f1_argmax", argmax(vec_out), 9);
    chk("f1_ready_low_full", psum_ready, 0);
    @(posedge clk); #1;
    chk("f1_hs_valid_low", vec_valid, 0);
    chk("f1_hs_ready", psum_ready, 1);
    @(negedge clk); vec_ready = 1'b0;

    // Quantization edges, last on lane 9
    beat(16'hFFFB, 1'b0);
    beat(16'h0123, 1'b0);
    beat(16'h7FFF, 1'b0);
    beat(16'h0FF0, 1'b0);
    beat(16'h0FFF, 1'b0);
    beat(16'h8000, 1'b0);
    beat(16'h1000, 1'b0);
    beat(16'h0000, 1'b0);
    beat(16'h0000, 1'b0);
    beat(16'h0000, 1'b1);
    chk("q_valid", vec_valid, 1);
    chk("q_vec", vec_out, 80'h000000FF00FFFFFF1200);
    chk("q_err", frame_err, 0);

    // Backpressure: producer keeps offering while the vector is pending
    held = vec_out;
    @(negedge clk);
    psum = 16'h0050; psum_valid = 1'b1; psum_last = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_ready_low", psum_ready, 0);
      chk("bp_vec_stable", vec_out, held);
      chk("bp_valid_high", vec_valid, 1);
    end
    vec_ready = 1'b1;
    @(posedge clk); #1;
    vec_ready = 1'b0;
    chk("bp_hs_valid_low", vec_valid, 0);
    chk("bp_hs_vec_cleared", vec_out, 0);
    chk("bp_hs_ready", psum_ready, 1);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    chk("bp_lane0_written", vec_out, 80'h05);

    // Early last: three more beats, last on beat 4 of the frame
    beat(16'h0050, 1'b0);
    beat(16'h0050, 1'b0);
    beat(16'h0050, 1'b1);
    chk("el_valid", vec_valid, 1);
    chk("el_vec", vec_out, 80'h00000000000005050505);
    chk("el_err", frame_err, 1);
    handshake();
    chk("el_err_cleared", frame_err, 0);

    // Missing last: frame closes on lane 9 regardless
    for (int k = 0; k < 10; k++) beat(16'(16 * (k + 1)), 1'b0);
    chk("ml_valid", vec_valid, 1);
    chk("ml_vec", vec_out, 80'h0A090807060504030201);
    chk("ml_err", frame_err, 1);
    held = vec_out;
    @(negedge clk);
    psum = 16'h00B0; psum_valid = 1'b1; psum_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ml_beat11_stalled", psum_ready, 0);
      chk("ml_vec_stable", vec_out, held);
    end
    vec_ready = 1'b1;
    @(posedge clk); #1;
    vec_ready = 1'b0;
    chk("ml_hs_valid_low", vec_valid, 0);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    chk("ml_beat11_lane0", vec_out, 80'h0B);
    beat(16'h00C0, 1'b0);
    for (int i = 0; i < 4; i++) beat(16'h0010, 1'b0);
    chk("ml_partial", vec_out, 80'h00000000010101010C0B);
    chk("ml_partial_not_valid", vec_valid, 0);

    // Async reset mid-frame, between edges
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arm_vec_valid", vec_valid, 0);
    chk("arm_vec_out", vec_out, 0);
    chk("arm_psum_ready", psum_ready, 0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 10; k++) beat(16'(16 * (9 - k)), k == 9);
    chk("arm_fresh_vec", vec_out, 80'h00010203040506070809);
    chk("arm_fresh_err", frame_err, 0);
    chk("arm_fresh_argmax", argmax(vec_out), 0);

    // Async reset while FULL drops the pending frame
    chk("arf_valid_before", vec_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arf_vec_valid", vec_valid, 0);
    chk("arf_vec_out", vec_out, 0);
    chk("arf_psum_ready", psum_ready, 0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 9; k++) beat(16'h0050, 1'b0);
    chk("arf_nine_not_valid", vec_valid, 0);
    beat(16'h0050, 1'b1);
    chk("arf_fresh_vec", vec_out, 80'h05050505050505050505);
    chk("arf_fresh_valid", vec_valid, 1);
    chk("arf_fresh_err", frame_err, 0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_collector.md
Name: score_collector

Overview:
- Producer side of the 80-bit packed score bus that the argmax classifier consumes.
- Accepts signed accumulator results from the PE array one at a time through a valid/ready handshake.
- Applies ReLU, requantizes and saturates each result to 8 bits, and packs the results into lane order.
- Presents the full vector, plus the classifier enable, through a second valid/ready handshake.

Parameters:
- NUM_PE, 10, number of lanes (classes) per frame.
- DATA_W, 8, packed lane width.
- ACC_W, 16, signed input accumulator width.
- SHIFT, 4, arithmetic right shift applied before clamping.
- IDX_W, 4, lane counter width; must satisfy 2**IDX_W >= NUM_PE.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- psum  in  ACC_W  signed accumulator result for the current lane.
- psum_valid  in  1  psum is valid this cycle.
- psum_last  in  1  marks the final result of a frame; qualified by psum_valid.
- psum_ready  out  1  block accepts psum this cycle.
- vec_out  out  NUM_PE*DATA_W  packed scores; lane k occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- vec_valid  out  1  vec_out holds a complete frame; drives the classifier enable.
- vec_ready  in  1  consumer has taken the frame.
- frame_err  out  1  the frame presented had a psum_last framing error; meaningful only while vec_valid is high.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=COLLECT, lane counter=0, vec_out=0, vec_valid=0, frame_err=0. psum_ready is 0 while reset is asserted.
- State COLLECT:
  - psum_ready=1 and vec_valid=0.
  - A beat is accepted when psum_valid & psum_ready at a clock edge.
  - An accepted beat writes lane[count] = sat(psum >>> SHIFT) and increments count.
- Quantization rule, sat(x):
  - Arithmetic shift, floor rounding.
  - x<0 gives 0. x>2**DATA_W-1 gives 2**DATA_W-1. Otherwise x[DATA_W-1:0].
- Frame completion: the frame closes on an accepted beat where either psum_last=1 or count==NUM_PE-1. At that edge: state moves to FULL, vec_valid=1 from the next cycle, count returns to 0.
- Early last: psum_last=1 with count<NUM_PE-1. Lanes count+1..NUM_PE-1 keep their cleared value 0, and frame_err=1.
- Missing last: frame closes at count==NUM_PE-1 with psum_last=0. frame_err=1 and the frame is still presented.
- A frame with psum_last=1 exactly on lane NUM_PE-1 gives frame_err=0.
- State FULL:
  - psum_ready=0 and vec_valid=1.
  - vec_out and frame_err are stable until the handshake.
  - On vec_valid & vec_ready: vec_out is cleared to 0, frame_err=0, state returns to COLLECT.
  - psum_ready is 1 in the cycle after the handshake. There is no same-cycle pass-through, so minimum frame period is NUM_PE+1 cycles.
- psum_valid while psum_ready=0 is ignored. The upstream source must hold psum stable until it is accepted.
- vec_ready while vec_valid=0 is ignored.
- Latency: the last accepted beat at edge N gives vec_valid high after edge N, i.e. visible in cycle N+1.
- Reset mid-frame: partial lanes are discarded and no vector is produced.
- Reset while FULL: the pending frame is dropped and vec_valid falls asynchronously.
- All outputs are registered except psum_ready, which is decoded from state and reset.

Decomposition:
- Shared package nn_pkg holds:
  - NUM_PE, DATA_W, ACC_W constants.
  - Lane slice offset function.
  - State enum {COLLECT, FULL}.
- One natural sub-module: relu_quant. Purely combinational: shift, ReLU and saturate ACC_W to DATA_W, with SHIFT as a parameter. Verified standalone.
- The FSM, lane counter and packing register stay in score_collector.

Test Plan:
- Full frame, no stalls:
  - Stimulus: psum = 0x0000,0x0010,...,0x0090 (lane k = 16k), last on lane 9, vec_ready=1.
  - Required: lane k = k. vec_valid high exactly one cycle after the 10th accept. frame_err=0. Classifier output = 9.
- Quantization edges:
  - Stimulus: psum -5, 0x0123, 0x7FFF, 0x0FF0, 0x0FFF.
  - Required: lanes 0x00, 0x12, 0xFF, 0xFF, 0xFF.
- Early last:
  - Stimulus: 4 beats of 0x0050 with last on beat 4.
  - Required: lanes 0-3 = 0x05, lanes 4-9 = 0x00, frame_err=1, vec_valid=1.
- Backpressure:
  - Stimulus: hold vec_ready=0 for 7 cycles after a frame completes, keep psum_valid=1.
  - Required: psum_ready=0 throughout, vec_out unchanged, no beat consumed. After the handshake, psum_ready=1 in the next cycle and lane 0 of the new frame is written.
- Missing last:
  - Stimulus: 12 beats with psum_last=0.
  - Required: frame closes after beat 10 with frame_err=1. Beats 11-12 are stalled (psum_ready=0) until the handshake, then start the next frame.
- Async reset:
  - Stimulus: assert reset between clock edges after 6 accepted beats, and again while FULL.
  - Required: vec_valid=0, vec_out=0 and psum_ready=0 immediately. After release, a fresh 10-beat frame is collected starting at lane 0.
